// File: rtl/ex_mem_pkg.sv
// Shared widths, memop codes and state encoding for the EX/MEM pipeline stage.
package ex_mem_pkg;

    localparam int ADDR_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_OP_W   = 2;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NOP        = 2'd0,
        MEM_OP_WRITE_REG  = 2'd1,
        MEM_OP_LOAD_WORD  = 2'd2,
        MEM_OP_STORE_WORD = 2'd3
    } memOp_t;

    typedef enum logic {
        MEM_STATE_IDLE   = 1'b0,
        MEM_STATE_ACCESS = 1'b1
    } memState_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = '0;
    localparam logic [ADDR_W-1:0]     ZERO_WORD = '0;

endpackage

// File: rtl/ex_mem.sv
// EX/MEM stage: registers ALU results for writeback and runs load/store accesses
// over a req/ack handshake, stalling upstream while an access is in flight.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ex_result,
    input  logic [ADDR_W-1:0]     ex_storeData,
    input  logic [MEM_OP_W-1:0]   ex_memop,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_writeEnable,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [ADDR_W-1:0]     mem_wdata,
    input  logic [ADDR_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall_req,
    output logic [ADDR_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  wb_writeEnable,
    output logic [ADDR_W-1:0]     fwd_data,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic                  fwd_writeEnable
);

    memState_t             r_state;
    logic                  r_memReq;
    logic                  r_memWe;
    logic [ADDR_W-1:0]     r_memAddr;
    logic [ADDR_W-1:0]     r_memWdata;
    logic [REG_ADDR_W-1:0] r_heldDest;
    logic [ADDR_W-1:0]     r_wbData;
    logic [REG_ADDR_W-1:0] r_wbDest;
    logic                  r_wbWe;

    memOp_t w_memop;
    assign w_memop = memOp_t'(ex_memop);

    // Every IDLE edge loads a bubble first, so loads, stores and NOPs leave
    // writeback quiet; only WRITE_REG and a load completion publish data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= MEM_STATE_IDLE;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= ZERO_WORD;
            r_memWdata <= ZERO_WORD;
            r_heldDest <= REG_ZERO;
            r_wbData   <= ZERO_WORD;
            r_wbDest   <= REG_ZERO;
            r_wbWe     <= 1'b0;
        end else begin
            case (r_state)
                MEM_STATE_IDLE: begin
                    r_wbData <= ZERO_WORD;
                    r_wbDest <= REG_ZERO;
                    r_wbWe   <= 1'b0;
                    r_memReq <= 1'b0;
                    if (!flush) begin
                        case (w_memop)
                            MEM_OP_WRITE_REG: begin
                                r_wbData <= ex_result;
                                r_wbDest <= ex_dest;
                                r_wbWe   <= ex_writeEnable && (ex_dest != REG_ZERO);
                            end
                            MEM_OP_LOAD_WORD: begin
                                r_memReq   <= 1'b1;
                                r_memWe    <= 1'b0;
                                r_memAddr  <= ex_result;
                                r_heldDest <= ex_dest;
                                r_state    <= MEM_STATE_ACCESS;
                            end
                            MEM_OP_STORE_WORD: begin
                                r_memReq   <= 1'b1;
                                r_memWe    <= 1'b1;
                                r_memAddr  <= ex_result;
                                r_memWdata <= ex_storeData;
                                r_state    <= MEM_STATE_ACCESS;
                            end
                            default: ;
                        endcase
                    end
                end
                MEM_STATE_ACCESS: begin
                    // The in-flight op is older than anything upstream, so ex_* and flush are ignored here.
                    if (mem_ack) begin
                        r_memReq <= 1'b0;
                        r_state  <= MEM_STATE_IDLE;
                        if (!r_memWe) begin
                            r_wbData <= mem_rdata;
                            r_wbDest <= r_heldDest;
                            r_wbWe   <= (r_heldDest != REG_ZERO);
                        end
                    end
                end
                default: r_state <= MEM_STATE_IDLE;
            endcase
        end
    end

    assign mem_req         = r_memReq;
    assign mem_we          = r_memWe;
    assign mem_addr        = r_memAddr;
    assign mem_wdata       = r_memWdata;
    assign stall_req       = (r_state == MEM_STATE_ACCESS);
    assign wb_data         = r_wbData;
    assign wb_dest         = r_wbDest;
    assign wb_writeEnable  = r_wbWe;
    assign fwd_data        = r_wbData;
    assign fwd_dest        = r_wbDest;
    assign fwd_writeEnable = r_wbWe;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus a randomized run
// against a word-array memory model and per-instruction writeback predictions.
module tb_ex_mem;

    logic        clk;
    logic        rst;
    logic [31:0] ex_result;
    logic [31:0] ex_storeData;
    logic [1:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_req;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        wb_writeEnable;
    logic [31:0] fwd_data;
    logic [4:0]  fwd_dest;
    logic        fwd_writeEnable;

    int total  = 0;
    int passed = 0;

    logic [31:0] memModel [0:15];

    logic [37:0] wbObs;
    logic [37:0] fwdObs;
    assign wbObs  = {wb_data, wb_dest, wb_writeEnable};
    assign fwdObs = {fwd_data, fwd_dest, fwd_writeEnable};

    ex_mem dut (
        .clk             (clk),
        .rst             (rst),
        .ex_result       (ex_result),
        .ex_storeData    (ex_storeData),
        .ex_memop        (ex_memop),
        .ex_dest         (ex_dest),
        .ex_writeEnable  (ex_writeEnable),
        .flush           (flush),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .stall_req       (stall_req),
        .wb_data         (wb_data),
        .wb_dest         (wb_dest),
        .wb_writeEnable  (wb_writeEnable),
        .fwd_data        (fwd_data),
        .fwd_dest        (fwd_dest),
        .fwd_writeEnable (fwd_writeEnable)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] res, input logic [31:0] sd,
                                 input logic [4:0] dest, input logic we, input logic fl);
        ex_memop       = op;
        ex_result      = res;
        ex_storeData   = sd;
        ex_dest        = dest;
        ex_writeEnable = we;
        flush          = fl;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall_req, wbObs, fwdObs} !== '0)
            $display("[TB] FAIL reset_state got req=%b we=%b addr=%h wdata=%h stall=%b wb=%h fwd=%h want all zero",
                     mem_req, mem_we, mem_addr, mem_wdata, stall_req, wbObs, fwdObs);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        applyStimulus(2'd2, 32'h40, 32'h0, 5'd4, 1'b1, 1'b0);
        tick();
        total++;
        if ({mem_req, stall_req} !== 2'b11)
            $display("[TB] FAIL rst_load_start got req=%b stall=%b want 1 1", mem_req, stall_req);
        else passed++;
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({mem_req, stall_req, wbObs, fwdObs} !== '0)
            $display("[TB] FAIL rst_mid_access got req=%b stall=%b wb=%h fwd=%h want zeros", mem_req, stall_req, wbObs, fwdObs);
        else passed++;
        rst = 1'b1;
        applyStimulus(2'd1, 32'h55, 32'h0, 5'd6, 1'b1, 1'b0);
        tick();
        total++;
        if ({wbObs, fwdObs, stall_req} !== {32'h55, 5'd6, 1'b1, 32'h55, 5'd6, 1'b1, 1'b0})
            $display("[TB] FAIL rst_recover got wb=%h fwd=%h stall=%b", wbObs, fwdObs, stall_req);
        else passed++;
    endtask

    task automatic test_alu();
        applyStimulus(2'd1, 32'h0000_00AB, 32'h0, 5'd5, 1'b1, 1'b0);
        tick();
        total++;
        if ({wbObs, fwdObs} !== {32'hAB, 5'd5, 1'b1, 32'hAB, 5'd5, 1'b1})
            $display("[TB] FAIL alu_wb got wb=%h fwd=%h want wb=fwd=%h", wbObs, fwdObs, {32'hAB, 5'd5, 1'b1});
        else passed++;
    endtask

    task automatic test_load();
        applyStimulus(2'd2, 32'h100, 32'h0, 5'd7, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({mem_req, mem_we, mem_addr, stall_req, wb_writeEnable, fwd_writeEnable} !== {1'b1, 1'b0, 32'h100, 1'b1, 2'b00})
                $display("[TB] FAIL load_wait%0d got req=%b we=%b addr=%h stall=%b wbwe=%b fwdwe=%b",
                         i, mem_req, mem_we, mem_addr, stall_req, wb_writeEnable, fwd_writeEnable);
            else passed++;
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                applyStimulus(2'd1, 32'h77, 32'h0, 5'd2, 1'b1, 1'b0);
            end
            tick();
        end
        mem_ack = 1'b0;
        total++;
        if ({wbObs, fwdObs, mem_req, stall_req} !== {32'hDEAD_BEEF, 5'd7, 1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 2'b00})
            $display("[TB] FAIL load_done got wb=%h fwd=%h req=%b stall=%b", wbObs, fwdObs, mem_req, stall_req);
        else passed++;
        tick();
        total++;
        if (wbObs !== {32'h77, 5'd2, 1'b1})
            $display("[TB] FAIL load_next_capture got wb=%h want %h", wbObs, {32'h77, 5'd2, 1'b1});
        else passed++;
    endtask

    task automatic test_store();
        applyStimulus(2'd3, 32'h20, 32'h1234, 5'd9, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, stall_req, wb_writeEnable, fwd_writeEnable} !==
                {1'b1, 1'b1, 32'h20, 32'h1234, 1'b1, 2'b00})
                $display("[TB] FAIL store_wait%0d got req=%b we=%b addr=%h wdata=%h stall=%b wbwe=%b",
                         i, mem_req, mem_we, mem_addr, mem_wdata, stall_req, wb_writeEnable);
            else passed++;
            if (i == 1) begin
                mem_ack = 1'b1;
                applyStimulus(2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
            end
            tick();
        end
        mem_ack = 1'b0;
        total++;
        if ({mem_req, stall_req, wbObs, fwdObs} !== '0)
            $display("[TB] FAIL store_done got req=%b stall=%b wb=%h fwd=%h want zeros", mem_req, stall_req, wbObs, fwdObs);
        else passed++;
    endtask

    task automatic test_flush_zero();
        applyStimulus(2'd1, 32'h99, 32'h0, 5'd3, 1'b1, 1'b1);
        tick();
        total++;
        if ({wbObs, fwdObs} !== '0)
            $display("[TB] FAIL flush_bubble got wb=%h fwd=%h want 0", wbObs, fwdObs);
        else passed++;
        applyStimulus(2'd1, 32'h99, 32'h0, 5'd0, 1'b1, 1'b0);
        tick();
        total++;
        if ({wbObs, fwdObs} !== {32'h99, 5'd0, 1'b0, 32'h99, 5'd0, 1'b0})
            $display("[TB] FAIL zero_dest_alu got wb=%h fwd=%h", wbObs, fwdObs);
        else passed++;
        applyStimulus(2'd2, 32'h8, 32'h0, 5'd0, 1'b1, 1'b0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5;
        applyStimulus(2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        mem_ack = 1'b0;
        total++;
        if (wbObs !== {32'h5, 5'd0, 1'b0})
            $display("[TB] FAIL zero_dest_load got wb=%h want %h", wbObs, {32'h5, 5'd0, 1'b0});
        else passed++;
    endtask

    task automatic test_access_ignore();
        applyStimulus(2'd2, 32'h200, 32'h0, 5'd11, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'($urandom), $urandom, $urandom, 5'($urandom), 1'b1, 1'b1);
            tick();
            total++;
            if ({mem_req, mem_we, mem_addr, stall_req} !== {1'b1, 1'b0, 32'h200, 1'b1})
                $display("[TB] FAIL ignore_ex%0d got req=%b we=%b addr=%h stall=%b", i, mem_req, mem_we, mem_addr, stall_req);
            else passed++;
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        total++;
        if ({wbObs, stall_req} !== {32'hCAFE_F00D, 5'd11, 1'b1, 1'b0})
            $display("[TB] FAIL ignore_complete got wb=%h stall=%b", wbObs, stall_req);
        else passed++;
        applyStimulus(2'd1, 32'h31, 32'h0, 5'd12, 1'b1, 1'b0);
        tick();
        mem_ack = 1'b0;
        total++;
        if ({wbObs, mem_req, stall_req} !== {32'h31, 5'd12, 1'b1, 2'b00})
            $display("[TB] FAIL idle_spurious_ack got wb=%h req=%b stall=%b", wbObs, mem_req, stall_req);
        else passed++;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [4:0]  dest;
        logic        we;
        logic        fl;
        logic [3:0]  idx;
        logic [31:0] res;
        logic [31:0] sd;
        logic [37:0] expWb;
        logic        isStore;
        int          k;
        for (int i = 0; i < 16; i++) memModel[i] = $urandom;
        for (int n = 0; n < 60; n++) begin
            op   = 2'($urandom_range(0, 3));
            dest = 5'($urandom);
            we   = 1'($urandom);
            fl   = ($urandom_range(0, 7) == 0);
            idx  = 4'($urandom);
            sd   = $urandom;
            res  = (op >= 2'd2) ? {26'd0, idx, 2'b00} : $urandom;
            mem_ack = ($urandom_range(0, 3) == 0);
            applyStimulus(op, res, sd, dest, we, fl);
            tick();
            if (fl || op < 2'd2) begin
                mem_ack = 1'b0;
                expWb = (!fl && op == 2'd1) ? {res, dest, we && (dest != 5'd0)} : 38'd0;
                total++;
                if ({wbObs, fwdObs, stall_req, mem_req} !== {expWb, expWb, 2'b00})
                    $display("[TB] FAIL rand%0d_capture got wb=%h fwd=%h stall=%b req=%b want wb=%h",
                             n, wbObs, fwdObs, stall_req, mem_req, expWb);
                else passed++;
            end else begin
                isStore = (op == 2'd3);
                k = $urandom_range(0, 3);
                mem_ack = 1'b0;
                for (int c = 0; c <= k; c++) begin
                    total++;
                    if (({mem_req, mem_we, mem_addr, stall_req, wb_writeEnable, fwd_writeEnable} !==
                         {1'b1, isStore, res, 1'b1, 2'b00}) || (isStore && mem_wdata !== sd))
                        $display("[TB] FAIL rand%0d_access%0d got req=%b we=%b addr=%h wdata=%h stall=%b want we=%b addr=%h wdata=%h",
                                 n, c, mem_req, mem_we, mem_addr, mem_wdata, stall_req, isStore, res, sd);
                    else passed++;
                    applyStimulus(2'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
                    if (c == k) begin
                        mem_ack   = 1'b1;
                        mem_rdata = isStore ? $urandom : memModel[idx];
                    end
                    tick();
                end
                mem_ack = 1'b0;
                if (isStore) begin
                    expWb = 38'd0;
                    memModel[idx] = sd;
                end else begin
                    expWb = {memModel[idx], dest, dest != 5'd0};
                end
                total++;
                if ({wbObs, fwdObs, stall_req, mem_req} !== {expWb, expWb, 2'b00})
                    $display("[TB] FAIL rand%0d_complete got wb=%h fwd=%h stall=%b req=%b want wb=%h",
                             n, wbObs, fwdObs, stall_req, mem_req, expWb);
                else passed++;
            end
        end
    endtask

    // Scenarios run back to back; each leaves the stage idle with mem_ack low.
    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_flush_zero();
        test_access_ignore();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
